// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-master LSU arbiter: request payload, master ids,
// lock states and pipeline stage-valid encodings.
package lsu_arb_pkg;

  typedef struct packed {
    logic        wren;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  funct3;
  } lsu_req_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam logic STAGE_IDLE  = 1'b0;
  localparam logic STAGE_BUSY  = 1'b1;
  localparam int   NUM_MASTERS = 2;

endpackage

// File: rtl/lsu_arb_rr2.sv
// Two-way picker: round-robin on ties (or fixed priority to master 0),
// a lone requester always wins. Holds the last-grant pointer.
module lsu_arb_rr2
  import lsu_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  master_id_e last_reg;

  // Pick the winner: on a tie favour the master not granted most recently.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (FIXED_PRIO || (last_reg == M1)) gnt = 2'b01;
      else                                gnt = 2'b10;
    end
  end

  // Pointer moves only on an actual grant; reset makes master 0 win first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_reg <= M1;
    else if (gnt[1]) last_reg <= M1;
    else if (gnt[0]) last_reg <= M0;
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the single LSU port between master 0 (core) and master 1 (debug).
// Stage A registers the winning request onto the LSU inputs; stage R
// captures load data and pulses rvalid back to the issuing master.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [2:0]  i_m0_funct3,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [2:0]  i_m1_funct3,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  input  logic        i_m1_lock,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_lsu_funct3,
  input  logic [31:0] i_ld_data
);

  lsu_req_t    req_pl [NUM_MASTERS];
  lsu_req_t    win_req;
  logic [1:0]  eff_req;
  logic [1:0]  gnt;
  logic        m0_block;
  lock_state_e lock_state_reg, lock_state_next;

  logic        a_valid_reg;
  master_id_e  a_id_reg;
  lsu_req_t    a_req_reg;

  logic [NUM_MASTERS-1:0] rvalid_vec;
  logic [31:0]            rdata_arr [NUM_MASTERS];

  assign req_pl[0] = {i_m0_wren, i_m0_addr, i_m0_data, i_m0_funct3};
  assign req_pl[1] = {i_m1_wren, i_m1_addr, i_m1_data, i_m1_funct3};

  // Master 0 is held off only while the lock is owned and still asserted,
  // so it can win in the very cycle the lock request drops.
  assign m0_block = (lock_state_reg == LOCKED) && i_m1_lock;
  assign eff_req  = {i_m1_req, i_m0_req & ~m0_block} & {2{~i_rst}};

  lsu_arb_rr2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr2 (
    .clk (i_clk),
    .rst (i_rst),
    .req (eff_req),
    .gnt (gnt)
  );

  assign o_m0_gnt = gnt[0];
  assign o_m1_gnt = gnt[1];
  assign win_req  = gnt[1] ? req_pl[1] : req_pl[0];

  // Lock state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lock_state_reg <= UNLOCKED;
    else       lock_state_reg <= lock_state_next;
  end

  // Lock is taken by a master-1 transfer with lock set, released when lock drops.
  always_comb begin
    lock_state_next = lock_state_reg;
    case (lock_state_reg)
      UNLOCKED: if (gnt[1] && i_m1_lock) lock_state_next = LOCKED;
      LOCKED:   if (!i_m1_lock)          lock_state_next = UNLOCKED;
      default:                           lock_state_next = UNLOCKED;
    endcase
  end

  // Stage A: capture the winner; when idle drop wren but keep address/data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_valid_reg <= STAGE_IDLE;
      a_id_reg    <= M0;
      a_req_reg   <= '0;
    end else if (|gnt) begin
      a_valid_reg <= STAGE_BUSY;
      a_id_reg    <= gnt[1] ? M1 : M0;
      a_req_reg   <= win_req;
    end else begin
      a_valid_reg    <= STAGE_IDLE;
      a_req_reg.wren <= 1'b0;
    end
  end

  assign o_lsu_addr   = a_req_reg.addr;
  assign o_lsu_data   = a_req_reg.data;
  assign o_lsu_wren   = a_req_reg.wren;
  assign o_lsu_funct3 = a_req_reg.funct3;

  // Stage R: one response slot per master; load data sampled at end of stage A.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
      localparam master_id_e ID = (gi == 0) ? M0 : M1;
      logic        take;
      logic        rvalid_reg;
      logic [31:0] rdata_reg;

      assign take = (a_valid_reg == STAGE_BUSY) && !a_req_reg.wren && (a_id_reg == ID);

      // Pulse rvalid for one cycle; rdata holds until the next load returns.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= take;
          if (take) rdata_reg <= i_ld_data;
        end
      end

      assign rvalid_vec[gi] = rvalid_reg;
      assign rdata_arr[gi]  = rdata_reg;
    end
  endgenerate

  assign o_m0_rvalid = rvalid_vec[0];
  assign o_m1_rvalid = rvalid_vec[1];
  assign o_m0_rdata  = rdata_arr[0];
  assign o_m1_rdata  = rdata_arr[1];

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-master arbiter that shares the single LSU load/store port between the core data path (master 0) and a debug/boot-loader port (master 1). It sits directly in front of `LSU`, registering the winning request onto the LSU address/data/write-enable/funct3 inputs and returning load data to the issuing master. It uses round-robin fairness by default, with an optional lock that gives master 1 exclusive ownership for read-modify-write sequences.

## Interface
- `FIXED_PRIO`, 0: 0 selects round-robin; 1 means master 0 always wins ties.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_mN_req`  in  1  master N request valid (N = 0, 1).
- `i_mN_wren`  in  1  1 = store, 0 = load.
- `i_mN_addr`  in  32  byte address.
- `i_mN_data`  in  32  store data.
- `i_mN_funct3`  in  3  access size/sign, passed to the LSU unchanged.
- `o_mN_gnt`  out  1  request accepted at this edge; combinational.
- `o_mN_rvalid`  out  1  one-cycle pulse; load data valid.
- `o_mN_rdata`  out  32  load data; holds its value until the next rvalid.
- `i_m1_lock`  in  1  master 1 exclusive-ownership request.
- `o_lsu_addr`, `o_lsu_data`  out  32  registered LSU address and store data.
- `o_lsu_wren`  out  1  registered LSU write enable.
- `o_lsu_funct3`  out  3  registered LSU funct3.
- `i_ld_data`  in  32  LSU `o_ld_data`; combinational from `o_lsu_addr`.

## Operation
- Handshake: a transfer occurs at an edge where `req && gnt`. The master holds its payload stable while `req=1 && gnt=0`. At most one `gnt` is high per cycle.
- `gnt` is asserted to the winner in every cycle that is not reset, not blocked by the lock, and has at least one request. Acceptance rate is one request per cycle.
- Pipeline stages:
  - Stage A (ACCESS) holds the accepted request and drives the `o_lsu_*` signals. For a load, `o_lsu_wren=1` only for the accepted store; it is 0 in an idle A-stage.
  - Stage R (RESP) holds the captured `i_ld_data` and the master id. It pulses `o_mN_rvalid` only for a load.
- Stores produce no response.
- Arbitration with both masters requesting and `FIXED_PRIO=0`: the grant goes to the master not granted most recently. The pointer updates only on an actual transfer. A single requester always wins.
- Lock FSM has two states, UNLOCKED and LOCKED:
  - UNLOCKED → LOCKED at the edge where master 1 transfers with `i_m1_lock=1`.
  - In LOCKED, `o_m0_gnt=0` and master 1 is granted whenever it requests.
  - LOCKED → UNLOCKED at the first edge with `i_m1_lock=0`. Master 0 may be granted in that same cycle.
- An idle A-stage drives `o_lsu_wren=0` and holds the previous address and data. This avoids a spurious store.
- `i_ld_data` is sampled at the end of the A-stage cycle only for loads.

## Timing
- Reset values:
  - All `o_mN_gnt` are combinationally 0 while `i_rst=1`.
  - `o_mN_rvalid=0`, `o_mN_rdata=0`, all `o_lsu_*=0`.
  - Lock state is UNLOCKED.
  - Round-robin pointer is set so master 0 wins the first tie.
- Load latency: transfer at edge k; `o_lsu_*` are valid in cycle k+1; `rvalid`/`rdata` are valid in cycle k+2.
- Store: `o_lsu_wren=1` for exactly cycle k+1; the LSU writes at edge k+2.
- Back-to-back requests: A-stage and R-stage overlap. A load followed by a store from the other master gives the load's rvalid and the store's wren in the same cycle.
- Simultaneous `i_m1_lock` rise and master 0 request in UNLOCKED: normal round-robin applies. The lock takes effect only after master 1's locked transfer.
- Reset mid-operation clears both stages. Any pending rvalid is dropped and is never emitted after reset.

## Structure
- Package `lsu_arb_pkg` holds:
  - typedef `lsu_req_t` with fields wren, addr, data, funct3.
  - enum `master_id_e` with values M0, M1.
  - enum `lock_state_e`.
  - localparams for the stage-valid encodings.
- Natural sub-module: `lsu_arb_rr2`, the two-way round-robin/fixed-priority picker holding the last-grant pointer. The lock mask is applied outside it.
- The top level holds the A/R pipeline registers and the lock FSM.

## Test plan
- Reset, then master 0 loads `0x0000_0010`, LSU returns `0xDEAD_BEEF` → `o_lsu_addr=0x10` at k+1; `o_m0_rvalid=1` and `o_m0_rdata=0xDEADBEEF` at k+2.
- Both masters hold store requests for 4 cycles → grants alternate M0, M1, M0, M1; `o_lsu_wren` is high for 4 consecutive cycles with the matching addresses.
- Master 1 issues a locked load of `0x1001_0000`, then a store, while master 0 requests continuously → `o_m0_gnt=0` until the cycle `i_m1_lock` falls, then master 0 is granted.
- `FIXED_PRIO=1` with both requesting for 3 cycles → master 0 is granted 3 times; master 1 is not granted until master 0 drops its request.
- Assert `i_rst` one cycle after a load transfer → no rvalid pulse; all `o_lsu_*=0`; first post-reset tie goes to master 0.
